dcache_line_memory: RTL and testbench
=====================================

Name: dcache_line_memory

Overview:
- Responder end of the data-cache/data-memory interface: a 256-bit-wide line-addressed backing memory.
- Serves line fills and dirty write-backs issued by the data cache controller.
- Has a fixed, parameterised access latency; completion is signalled by a single-cycle ack pulse.
- Sits between the data cache and the testbench/top level; it is the only agent that drives ack.

Parameters:
- LATENCY, 10: clock edges from request acceptance to ack assertion; legal range 1..255.
- DEPTH_LOG2, 9: log2 of the number of 32-byte lines (default 512 lines = 16 KiB).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  request valid; the initiator holds it high until ack.
- write_i  input  1  1 = line write (write-back), 0 = line read (fill); sampled at acceptance.
- addr_i  input  32  byte address; index = addr_i[DEPTH_LOG2+4:5]; addr_i[4:0] ignored.
- data_i  input  256  write line data; sampled at acceptance.
- ack_o  output  1  completion pulse, exactly one cycle per accepted request.
- data_o  output  256  read line data; valid in the ack cycle and held until the next read completes.
- err_o  output  1  address error flag (see Optional Feature); tied 0 when the feature is disabled.

Behaviour:
- State machine: IDLE, BUSY, ACK. State is registered.
- Reset (rst_i low, asynchronous):
  - state = IDLE; ack_o = 0; data_o = 0; err_o = 0; latency counter = 0.
  - Memory array is not cleared.
- IDLE:
  - On a rising edge with enable_i = 1, the request is accepted: write_i, index and data_i are captured into internal registers.
  - LATENCY = 1: go directly to ACK.
  - Otherwise: counter = LATENCY-2, go to BUSY.
  - enable_i = 0: stay in IDLE.
- BUSY:
  - Counter decrements each edge.
  - Edge with counter = 0: go to ACK.
  - Inputs are ignored while busy. enable_i dropping mid-transaction does not abort the transaction; ack is still issued.
- Edge entering ACK:
  - Captured write: mem[index] <= captured data; data_o unchanged.
  - Captured read: data_o <= mem[index].
  - ack_o <= 1.
- Resulting latency: ack_o is high in the cycle following the LATENCY-th edge counted from the accepting edge.
- ACK:
  - Lasts exactly one cycle; next edge: ack_o <= 0, state <= IDLE.
  - enable_i is not sampled in ACK. A request held high across ack (e.g. write-back followed immediately by fill) is accepted on the next edge from IDLE, giving a minimum one-cycle gap between requests.
- Ordering and hazards:
  - Write commit happens only at the ACK edge.
  - A read following a write to the same index returns the new data.
  - No read/write hazard exists because only one request is outstanding at a time.
- Reset mid-operation:
  - The transaction is abandoned; no ack is issued.
  - A pending write is not committed.
- Inputs are never sampled outside the acceptance edge; changes during BUSY have no effect.

Optional Feature:
- Macro: DCACHE_LINE_MEMORY_ADDR_CHECK_EN.
- Enabled, error condition: at acceptance, an address error is flagged if addr_i[31:DEPTH_LOG2+5] != 0 or addr_i[4:0] != 0.
- Enabled, error response:
  - ack is still issued with normal latency.
  - err_o = 1 in the ack cycle only.
  - A write is suppressed (memory unchanged).
  - A read returns data_o = 0.
- Enabled, reset: err_o resets to 0.
- Disabled: no check; upper address bits and offset are ignored; err_o is constant 0.

Test Plan:
- Fixed-latency write: reset, LATENCY = 10; write addr 0x0000_0040 with data 256'hA5 repeated, hold enable_i -> ack_o high for exactly 1 cycle, 10 edges after acceptance; data_o stays 0.
- Read-after-write: read addr 0x0000_0040 -> ack after 10 edges; data_o = 256'hA5 pattern and held after ack until the next read completes.
- Back-to-back write-back then fill: write 0x0000_0400 ack'd while enable_i stays high, then write_i = 0 and addr = 0x0000_0800 -> second request accepted one cycle after the ack cycle; exactly two ack pulses.
- LATENCY = 1 build: read any line -> ack_o high in the cycle right after the accepting edge; no BUSY cycle.
- Reset mid-BUSY: write 0x0000_0060, assert rst_i low 5 edges in -> no ack; a subsequent read of 0x0000_0060 returns the old contents.
- With DCACHE_LINE_MEMORY_ADDR_CHECK_EN: write to 0x0010_0000 (out of range at DEPTH_LOG2 = 9) -> ack with err_o = 1 for one cycle, memory unchanged; read from 0x0000_0044 (misaligned) -> err_o = 1, data_o = 0.

Source files
------------

// File: rtl/dcache_line_memory.sv
// dcache_line_memory
// Responder end of the data-cache / data-memory interface. A 256-bit wide,
// line-addressed backing store that serves line fills (reads) and dirty
// write-backs (writes). Each accepted request completes after LATENCY clock
// edges with a single-cycle ack pulse. Only one request is outstanding at a
// time.
//
// Optional feature: define DCACHE_LINE_MEMORY_ADDR_CHECK_EN to flag requests
// whose address has non-zero bits above the array or a non-zero line offset.
// A flagged request is still acked with normal latency and raises err_o for
// the ack cycle. A flagged write leaves memory unchanged, and a flagged read
// returns zero. Without the macro, err_o is tied low and the unused address
// bits are ignored.
//
// State table:
//   IDLE | waiting for enable_i; the request is captured on the accepting edge
//   BUSY | latency countdown; inputs are ignored
//   ACK  | ack_o high for exactly one cycle; enable_i is not sampled
module dcache_line_memory #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit DIRECT_ACK = (LATENCY == 1);
    // A request spends one edge being accepted and one edge entering ACK.
    // BUSY therefore counts the remaining LATENCY-2 edges down to zero.
    localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_write;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [255:0]          r_wdata;
    logic                  r_err_req;
    logic                  r_ack;
    logic [255:0]          r_rdata;
    logic                  r_err;
    logic [255:0]          r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_ack;
    logic                  w_addr_err;
    logic                  w_cur_write;
    logic                  w_cur_err;
    logic [DEPTH_LOG2-1:0] w_in_index;
    logic [DEPTH_LOG2-1:0] w_cur_index;
    logic [255:0]          w_cur_wdata;

    assign w_in_index = addr_i[DEPTH_LOG2+4:5];

`ifdef DCACHE_LINE_MEMORY_ADDR_CHECK_EN
    assign w_addr_err = (addr_i[31:DEPTH_LOG2+5] != '0) || (addr_i[4:0] != 5'd0);
    assign err_o      = r_err;
`else
    logic w_unused_addr;
    assign w_addr_err    = 1'b0;
    assign err_o         = 1'b0;
    assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0], r_err};
`endif

    assign w_accept    = (r_state == IDLE) && enable_i;
    assign w_enter_ack = (w_accept && DIRECT_ACK) ||
                         ((r_state == BUSY) && (r_cnt == 8'd0));

    // With LATENCY = 1, ACK is entered on the accepting edge itself. The
    // capture registers are not loaded yet, so the live inputs are used.
    assign w_cur_write = (r_state == IDLE) ? write_i    : r_write;
    assign w_cur_index = (r_state == IDLE) ? w_in_index : r_index;
    assign w_cur_wdata = (r_state == IDLE) ? data_i     : r_wdata;
    assign w_cur_err   = (r_state == IDLE) ? w_addr_err : r_err_req;

    assign ack_o  = r_ack;
    assign data_o = r_rdata;

    // Line array: a write commits only on the edge entering ACK. The array is
    // not cleared by reset, and an abandoned write never commits.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_enter_ack && w_cur_write && !w_cur_err) begin
            r_mem[w_cur_index] <= w_cur_wdata;
        end
    end

    // Sequencing FSM with registered ack/data/err outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_write   <= 1'b0;
            r_index   <= '0;
            r_wdata   <= '0;
            r_err_req <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_write   <= write_i;
                        r_index   <= w_in_index;
                        r_wdata   <= data_i;
                        r_err_req <= w_addr_err;
                        if (DIRECT_ACK) begin
                            r_state <= ACK;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_enter_ack) begin
                r_ack <= 1'b1;
                r_err <= w_cur_err;
                if (!w_cur_write) begin
                    r_rdata <= w_cur_err ? '0 : r_mem[w_cur_index];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_line_memory.sv
// Bench for dcache_line_memory. The main instance (LATENCY=10, DEPTH_LOG2=9)
// is checked every cycle against a request-level model. A second instance at
// LATENCY=1 receives directed checks.
`timescale 1ns/1ps
module tb_dcache_line_memory;

    localparam int LAT = 10;
    localparam int DL2 = 9;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i, write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         err_o;

    logic         en1, wr1;
    logic [31:0]  ad1;
    logic [255:0] di1;
    logic         ack1;
    logic [255:0] do1;
    logic         err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    dcache_line_memory #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
        .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o), .err_o(err_o)
    );

    dcache_line_memory #(.LATENCY(1), .DEPTH_LOG2(4)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(en1), .write_i(wr1),
        .addr_i(ad1), .data_i(di1), .ack_o(ack1), .data_o(do1), .err_o(err1)
    );

    // ---------------- request-level model ----------------
    logic [255:0] m_mem [int];
    int           m_edge = 0;
    int           m_free = 0;
    int           m_done = 0;
    bit           m_busy = 0;
    bit           m_wr, m_err;
    int           m_idx;
    logic [255:0] m_wd;
    logic         exp_ack  = 1'b0;
    logic         exp_err  = 1'b0;
    logic [255:0] exp_data = '0;
    int           dut_acks = 0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % (32'd1 << DL2));
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef DCACHE_LINE_MEMORY_ADDR_CHECK_EN
        return ((a >> (DL2 + 5)) != 0) || ((a % 32) != 0);
`else
        return (a === 32'hxxxx_xxxx);
`endif
    endfunction

    initial forever begin
        @(posedge clk_i or negedge rst_i);
        if (rst_i !== 1'b1) begin
            m_busy   = 0;
            m_free   = 0;
            exp_ack  = 1'b0;
            exp_err  = 1'b0;
            exp_data = '0;
        end else begin
            m_edge++;
            exp_ack = 1'b0;
            exp_err = 1'b0;
            if (!m_busy && m_edge >= m_free && enable_i === 1'b1) begin
                m_busy = 1;
                m_wr   = write_i;
                m_idx  = line_of(addr_i);
                m_wd   = data_i;
                m_err  = addr_bad(addr_i);
                m_done = m_edge + LAT - 1;
            end
            if (m_busy && m_edge == m_done) begin
                m_busy  = 0;
                m_free  = m_edge + 2;
                exp_ack = 1'b1;
                exp_err = m_err;
                if (m_wr) begin
                    if (!m_err) m_mem[m_idx] = m_wd;
                end else begin
                    exp_data = m_err ? '0 : (m_mem.exists(m_idx) ? m_mem[m_idx] : '0);
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk_i);
        checks++;
        if (ack_o !== exp_ack || err_o !== exp_err || data_o !== exp_data) begin
            failures++;
            $display("FAIL cycle_compare t=%0t ack=%b req %b err=%b req %b data=%h req %h",
                     $time, ack_o, exp_ack, err_o, exp_err, data_o, exp_data);
        end
        if (ack_o === 1'b1) dut_acks++;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at a negedge. Drives a request and returns at the negedge where
    // ack is seen; k is the number of edges taken.
    task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d, output int k);
        enable_i = 1'b1;
        write_i  = w;
        addr_i   = a;
        data_i   = d;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
        end while (ack_o !== 1'b1 && k < 300);
        if (ack_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout addr=%h waited=%0d", a, k);
        end
    endtask

    task automatic idle1;
        enable_i = 1'b0;
        @(negedge clk_i);
    endtask

    localparam logic [255:0] P_A5   = {32{8'hA5}};
    localparam logic [255:0] P_800  = {8{32'h0800_C0DE}};
    localparam logic [255:0] P_400  = {8{32'h0400_BEEF}};
    localparam logic [255:0] P_OLD  = {8{32'h0060_0A1D}};
    localparam logic [255:0] P_NEW  = {8{32'h0060_FEED}};
    localparam logic [255:0] P_ZERO = {8{32'h0000_1234}};
    localparam logic [255:0] P_BAD  = {8{32'hBAD0_BAD0}};
    localparam logic [255:0] P_L1   = {8{32'h1111_2222}};

    initial begin
        int k;
        int a0;
        rst_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
        en1 = 1'b0; wr1 = 1'b0; ad1 = '0; di1 = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_ack", 256'(ack_o), 256'(0));
        chk("reset_data", data_o, '0);
        chk("reset_err", 256'(err_o), 256'(0));
        rst_i = 1'b1;
        @(negedge clk_i);

        // Fixed-latency write
        req(1'b1, 32'h0000_0040, P_A5, k);
        chk("wr_latency", 256'(k), 256'(10));
        chk("wr_data_o_unchanged", data_o, '0);
        idle1();
        chk("wr_ack_one_cycle", 256'(ack_o), 256'(0));

        // Read-after-write, data held after ack
        req(1'b0, 32'h0000_0040, '0, k);
        chk("rd_latency", 256'(k), 256'(10));
        chk("rd_data", data_o, P_A5);
        idle1();
        repeat (3) @(negedge clk_i);
        chk("rd_data_held", data_o, P_A5);

        // Preload lines used later
        req(1'b1, 32'h0000_0800, P_800, k);  idle1();
        req(1'b1, 32'h0000_0060, P_OLD, k);  idle1();
        req(1'b1, 32'h0000_0000, P_ZERO, k); idle1();

        // Back-to-back write-back then fill with enable held across ack
        a0 = dut_acks;
        req(1'b1, 32'h0000_0400, P_400, k);
        req(1'b0, 32'h0000_0800, '0, k);
        chk("b2b_gap_edges", 256'(k), 256'(11));
        chk("b2b_fill_data", data_o, P_800);
        idle1();
        chk("b2b_ack_count", 256'(dut_acks - a0), 256'(2));

        // enable_i dropped mid-transaction: ack still arrives; changed inputs ignored
        enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0400; data_i = '0;
        repeat (3) @(negedge clk_i);
        enable_i = 1'b0; write_i = 1'b1; addr_i = 32'h0000_0060; data_i = P_BAD;
        k = 3;
        while (ack_o !== 1'b1 && k < 300) begin
            @(negedge clk_i);
            k++;
        end
        chk("drop_latency", 256'(k), 256'(10));
        chk("drop_data", data_o, P_400);
        @(negedge clk_i);

        // Reset five edges into a write: no ack, no commit
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0060; data_i = P_NEW;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b0;
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_mid_data", data_o, '0);
        rst_i = 1'b1;
        repeat (12) @(negedge clk_i);
        req(1'b0, 32'h0000_0060, '0, k);
        chk("rst_old_contents", data_o, P_OLD);
        idle1();

        // Address checking (out-of-range write, misaligned read)
        req(1'b1, 32'h0010_0000, P_BAD, k);
`ifdef DCACHE_LINE_MEMORY_ADDR_CHECK_EN
        chk("oor_err", 256'(err_o), 256'(1));
`else
        chk("oor_err", 256'(err_o), 256'(0));
`endif
        idle1();
        chk("err_one_cycle", 256'(err_o), 256'(0));
        req(1'b0, 32'h0000_0000, '0, k);
`ifdef DCACHE_LINE_MEMORY_ADDR_CHECK_EN
        chk("oor_mem_unchanged", data_o, P_ZERO);
`else
        chk("oor_mem_aliased", data_o, P_BAD);
`endif
        idle1();
        req(1'b0, 32'h0000_0044, '0, k);
`ifdef DCACHE_LINE_MEMORY_ADDR_CHECK_EN
        chk("misaligned_err", 256'(err_o), 256'(1));
        chk("misaligned_data", data_o, '0);
`else
        chk("misaligned_err", 256'(err_o), 256'(0));
        chk("misaligned_data", data_o, P_A5);
`endif
        idle1();

        // LATENCY = 1 instance: ack on the cycle right after the accepting edge
        en1 = 1'b1; wr1 = 1'b1; ad1 = 32'h0000_0020; di1 = P_L1;
        @(negedge clk_i);
        chk("l1_wr_ack", 256'(ack1), 256'(1));
        en1 = 1'b0;
        @(negedge clk_i);
        chk("l1_ack_drop", 256'(ack1), 256'(0));
        en1 = 1'b1; wr1 = 1'b0; di1 = '0;
        @(negedge clk_i);
        chk("l1_rd_ack", 256'(ack1), 256'(1));
        chk("l1_rd_data", do1, P_L1);
        @(negedge clk_i);
        chk("l1_gap_cycle", 256'(ack1), 256'(0));
        @(negedge clk_i);
        chk("l1_second_ack", 256'(ack1), 256'(1));
        en1 = 1'b0;
        @(negedge clk_i);
        chk("l1_idle_ack", 256'(ack1), 256'(0));
        chk("l1_data_held", do1, P_L1);
        chk("l1_err", 256'(err1), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
